uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 The block SHALL have parameter CLOCKS_PER_BIT, default 87, meaning the clock cycles per serial bit; legal range is 2 to 65535.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock, rising-edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port output_valid, input, 1 bit: request to transmit output_data.
REQ-005 The block SHALL have port output_data, input, 8 bits: the byte to transmit, sampled with output_valid.
REQ-006 The block SHALL have port serial_tx, output, 1 bit: the UART line, idle high, registered.
REQ-007 The block SHALL have port active, output, 1 bit: high while a frame is on the line, registered.

Function
REQ-008 The block SHALL use the states IDLE, START, DATA, PARITY (when enabled) and STOP.
REQ-009 In IDLE, on a rising edge with output_valid=1, the block SHALL latch output_data, enter START, drive serial_tx=0 and set active=1 at that same edge.
REQ-010 Each of START, DATA-bit, PARITY and STOP SHALL last exactly CLOCKS_PER_BIT cycles, timed by a bit counter cleared on each bit boundary.
REQ-011 The DATA state SHALL transmit the 8 latched bits LSB first, with a 3-bit index wrapping 7->0 on exit.
REQ-012 The STOP state SHALL drive serial_tx=1.
REQ-013 At the end of STOP, the block SHALL enter IDLE and clear active at that same edge.
REQ-014 Total frame duration SHALL be 10*CLOCKS_PER_BIT cycles, or 11*CLOCKS_PER_BIT cycles with parity enabled.
REQ-015 output_valid while active=1 SHALL be ignored: no queuing, and the latched data SHALL be unaffected.
REQ-016 The earliest next acceptance SHALL be the edge after active falls, giving a minimum gap of one idle cycle (serial_tx=1) between frames.
REQ-017 output_data SHALL be don't-care except at the accepting edge.

Reset
REQ-018 Asserting reset_n=0 SHALL immediately force state=IDLE, serial_tx=1 and active=0, and clear the counters and data register.
REQ-019 A reset mid-frame SHALL abort the frame with no partial stop bit.
REQ-020 After reset_n rises, the first acceptance SHALL be possible on the next rising edge.

Configuration
REQ-021 When macro UART_TX_PARITY_EN is defined, a PARITY bit equal to the XOR of the 8 data bits (even parity) SHALL be inserted between DATA and STOP.
REQ-022 When macro UART_TX_PARITY_EN is undefined, DATA SHALL go directly to STOP and no parity logic SHALL exist.

Structure
REQ-023 Package uart_pkg SHALL hold the state enum type, DATA_BITS=8, and the IDLE_LEVEL/START_LEVEL/STOP_LEVEL constants.
REQ-024 Sub-module uart_baud_counter SHALL be parameterised by CLOCKS_PER_BIT, with a counter width of $clog2(CLOCKS_PER_BIT), a clear input and a bit_done pulse output.
REQ-025 The top level SHALL contain the FSM, the data shift/index logic and the output registers.

Verification (CLOCKS_PER_BIT=5, 10 ns clock)
REQ-026 A bench SHALL cover: after reset, with no valid for 50 cycles -> serial_tx=1 and active=0 throughout.
REQ-027 A bench SHALL cover: a one-cycle pulse of output_valid with 0x53 -> serial_tx shows 0,1,1,0,0,1,0,1,0,1, each bit held 5 cycles, and active is high for exactly 50 cycles.
REQ-028 A bench SHALL cover: with UART_TX_PARITY_EN defined, 0x53 -> parity bit 0 before stop, frame length 55 cycles; 0x01 -> parity bit 1.
REQ-029 A bench SHALL cover: output_valid held high continuously with 0xA5 -> back-to-back frames separated by exactly 1 idle-high cycle.
REQ-030 A bench SHALL cover: output_valid with 0xFF pulsed at cycle 20 of an in-flight 0x00 frame -> it is ignored, and the 0x00 frame completes unchanged.
REQ-031 A bench SHALL cover: reset_n pulled low during DATA bit 3 -> serial_tx=1 and active=0 asynchronously, with no further line activity until a new valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: frame constants, line levels
// and the transmitter state type.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit state).
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;
`endif

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts clock cycles within one serial bit and pulses
// bit_done_o on the last cycle of the bit. Held at zero while clear_i is high.
module uart_baud_counter #(
  parameter int unsigned CLOCKS_PER_BIT = 87
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic bit_done_o
);

  localparam int unsigned CNT_W = $clog2(CLOCKS_PER_BIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_done_o = (cnt_q == CNT_W'(CLOCKS_PER_BIT - 1));

  // Next count: wrap to zero on every bit boundary or while held clear.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear_i || bit_done_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: 8 data bits LSB first, one start bit, one stop bit,
// CLOCKS_PER_BIT clock cycles per bit. Requests arriving while a frame is in
// flight are dropped.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit before stop).
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCKS_PER_BIT = 87
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 output_valid,
  input  logic [DATA_BITS-1:0] output_data,
  output logic                 serial_tx,
  output logic                 active
);

  state_e               state_q;
  logic [DATA_BITS-1:0] data_q;
  logic [2:0]           idx_q;
  logic                 bit_done;
  logic                 cnt_clear;

  // The bit timer is parked at zero in IDLE so START gets a full bit period
  // counted from the accepting edge.
  assign cnt_clear = (state_q == IDLE);

  uart_baud_counter #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_baud_counter (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .clear_i   (cnt_clear),
    .bit_done_o(bit_done)
  );

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      data_q    <= '0;
      idx_q     <= '0;
      serial_tx <= IDLE_LEVEL;
      active    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (output_valid) begin
            data_q    <= output_data;
            state_q   <= START;
            serial_tx <= START_LEVEL;
            active    <= 1'b1;
          end
        end
        START: begin
          if (bit_done) begin
            state_q   <= DATA;
            idx_q     <= '0;
            serial_tx <= data_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (idx_q == 3'(DATA_BITS - 1)) begin
              idx_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= PARITY;
              serial_tx <= ^data_q;
`else
              state_q   <= STOP;
              serial_tx <= STOP_LEVEL;
`endif
            end else begin
              idx_q     <= idx_q + 3'd1;
              serial_tx <= data_q[idx_q + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            state_q   <= STOP;
            serial_tx <= STOP_LEVEL;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            state_q   <= IDLE;
            serial_tx <= IDLE_LEVEL;
            active    <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          serial_tx <= IDLE_LEVEL;
          active    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter with CLOCKS_PER_BIT=5, 10 ns clock.
// Honours UART_TX_PARITY_EN when the same macro is defined for the build.
module tb_uart_transmitter;

  localparam int CPB = 5;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       output_valid;
  logic [7:0] output_data;
  logic       serial_tx;
  logic       active;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  uart_transmitter #(
    .CLOCKS_PER_BIT(CPB)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .output_valid(output_valid),
    .output_data (output_data),
    .serial_tx   (serial_tx),
    .active      (active)
  );

  // Expected line level for frame bit position i of byte b.
  function automatic logic model_bit(input logic [7:0] b, input int i);
    logic [7:0] sh;
    int         ones;
    if (i == 0) return 1'b0;
    if (i >= 1 && i <= 8) begin
      sh = b >> (i - 1);
      return sh[0];
    end
`ifdef UART_TX_PARITY_EN
    if (i == 9) begin
      ones = 0;
      for (int j = 0; j < 8; j++) ones += int'(b[j]);
      return (ones % 2) == 1;
    end
`endif
    ones = 0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check($sformatf("%s_tx[%0d]", tag, i), serial_tx, 1'b1);
      check($sformatf("%s_active[%0d]", tag, i), active, 1'b0);
    end
  endtask

  // Called in the low clock phase; the request is taken at the next rising edge.
  task automatic run_frame(input logic [7:0] b, input bit hold, input int inject_at,
                           input int abort_at);
    output_valid = 1'b1;
    output_data  = b;
    @(posedge clock);
    for (int k = 0; k < NBITS * CPB; k++) begin
      @(negedge clock);
      check($sformatf("tx[%02h,c%0d]", b, k), serial_tx, model_bit(b, k / CPB));
      check($sformatf("active[%02h,c%0d]", b, k), active, 1'b1);
      if (k == abort_at) begin
        #2 reset_n = 1'b0;
        #1;
        check($sformatf("abort_tx[%02h]", b), serial_tx, 1'b1);
        check($sformatf("abort_active[%02h]", b), active, 1'b0);
        output_valid = 1'b0;
        return;
      end
      if (k == 0 && !hold) begin
        output_valid = 1'b0;
        output_data  = 8'($urandom);
      end
      if (k == inject_at) begin
        output_valid = 1'b1;
        output_data  = 8'hFF;
      end
      if (inject_at >= 0 && k == inject_at + 1) begin
        output_valid = 1'b0;
        output_data  = 8'($urandom);
      end
    end
    @(negedge clock);
    check($sformatf("gap_tx[%02h]", b), serial_tx, 1'b1);
    check($sformatf("gap_active[%02h]", b), active, 1'b0);
  endtask

  initial begin
    logic [7:0] rb;
    int         gap;

    reset_n      = 1'b0;
    output_valid = 1'b0;
    output_data  = 8'h00;
    repeat (3) @(negedge clock);
    check("reset_tx", serial_tx, 1'b1);
    check("reset_active", active, 1'b0);
    reset_n = 1'b1;

    // Quiet line after reset.
    idle_cycles("idle", 50);

    // Reference byte and a parity-1 byte.
    run_frame(8'h53, 1'b0, -1, -1);
    run_frame(8'h01, 1'b0, -1, -1);

    // Request held high: back-to-back frames with one idle cycle between.
    run_frame(8'hA5, 1'b1, -1, -1);
    run_frame(8'hA5, 1'b1, -1, -1);
    run_frame(8'hA5, 1'b0, -1, -1);

    // Request during an in-flight frame is dropped.
    idle_cycles("pre_inject", 2);
    run_frame(8'h00, 1'b0, 20, -1);
    idle_cycles("post_inject", 3);

    // Random bytes with random idle spacing.
    repeat (6) begin
      rb  = 8'($urandom);
      gap = int'($urandom_range(0, 3));
      idle_cycles("rand_gap", gap);
      run_frame(rb, 1'b0, -1, -1);
    end

    // Reset asserted during data bit 3 aborts the frame.
    run_frame(8'($urandom), 1'b0, -1, CPB * 4 + 2);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check($sformatf("in_reset_tx[%0d]", i), serial_tx, 1'b1);
      check($sformatf("in_reset_active[%0d]", i), active, 1'b0);
    end
    reset_n = 1'b1;
    idle_cycles("post_abort", 30);
    run_frame(8'h96, 1'b0, -1, -1);

    // Request ready at the first rising edge after reset release.
    @(negedge clock);
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    run_frame(8'h3C, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
